ddr3_burst_datapath: RTL and testbench

Data-path stage between the DDR3 controller core and the memory-side pins. It converts one 64-bit CPU write word into a burst of eight 8-bit beats for the memory. It also assembles eight 8-bit read beats from the memory into one 64-bit word for the CPU side. A read timeout guards against missing beats.

---
 rtl/ddr3_pkg.sv | 15 +
 rtl/ddr3_rd_assembler.sv | 104 ++++++++++
 rtl/ddr3_burst_datapath.sv | 114 +++++++++++
 tb/tb_ddr3_burst_datapath.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared types and default geometry for the DDR3 burst data path.
package ddr3_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } dp_state_t;

  localparam int DDR3_BL         = 8;
  localparam int DDR3_BEAT_W     = 8;
  localparam int DDR3_WORD_W     = 64;
  localparam int DDR3_RD_TIMEOUT = 16;

endpackage

// File: rtl/ddr3_rd_assembler.sv
// Read-side beat collector: shadow register, beat index and beat-less timeout.
// Optional per-beat even parity tracking under DDR3_DP_PARITY_EN.
module ddr3_rd_assembler
  import ddr3_pkg::*;
#(
  parameter int BL         = DDR3_BL,
  parameter int BEAT_W     = DDR3_BEAT_W,
  parameter int RD_TIMEOUT = DDR3_RD_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   active,
  input  logic [BEAT_W-1:0]      beat,
  input  logic                   beat_valid,
`ifdef DDR3_DP_PARITY_EN
  input  logic                   beat_par,
  output logic                   par_err,
`endif
  output logic                   fin,
  output logic                   abort,
  output logic [BL*BEAT_W-1:0]   word,
  output logic                   word_valid,
  output logic                   err
);

  localparam int IW = (BL > 1) ? $clog2(BL) : 1;
  localparam int TW = $clog2(RD_TIMEOUT);
  localparam logic [IW-1:0] LAST = IW'(BL - 1);
  localparam logic [TW-1:0] TLIM = TW'(RD_TIMEOUT - 1);

  logic [BL-1:0][BEAT_W-1:0] shadow, shadow_nxt;
  logic [IW-1:0]             idx;
  logic [TW-1:0]             tcnt;

  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[idx] = beat;
  end

  // A beat always beats the timeout, even on the limit cycle.
  assign fin   = active &&  beat_valid && (idx == LAST);
  assign abort = active && !beat_valid && (tcnt == TLIM);

`ifdef DDR3_DP_PARITY_EN
  logic par_flag;
  logic par_bad;
  assign par_bad = (^beat) ^ beat_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_flag <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (start) begin
        par_flag <= 1'b0;
      end else if (active && beat_valid) begin
        par_flag <= par_flag | par_bad;
        if (idx == LAST) par_err <= par_flag | par_bad;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      idx        <= '0;
      tcnt       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      err        <= 1'b0;
      if (start) begin
        shadow <= '0;
        idx    <= '0;
        tcnt   <= '0;
      end else if (active) begin
        if (beat_valid) begin
          shadow <= shadow_nxt;
          tcnt   <= '0;
          if (idx == LAST) begin
            word       <= shadow_nxt;
            word_valid <= 1'b1;
            idx        <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end else if (tcnt == TLIM) begin
          // partial beats are dropped; word keeps its last good value
          err  <= 1'b1;
          tcnt <= '0;
          idx  <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_burst_datapath.sv
// DDR3 data path: 64-bit write word -> BL beats, BL read beats -> 64-bit word.
// Define DDR3_DP_PARITY_EN to add RD_BEAT_PAR / RD_PAR_ERR.
module ddr3_burst_datapath
  import ddr3_pkg::*;
#(
  parameter int BL         = DDR3_BL,
  parameter int BEAT_W     = DDR3_BEAT_W,
  parameter int WORD_W     = DDR3_WORD_W,
  parameter int RD_TIMEOUT = DDR3_RD_TIMEOUT
) (
  input  logic              CPU_CLK,
  input  logic              RESET,
  input  logic              WR_REQ,
  input  logic [WORD_W-1:0] WR_WORD,
  output logic              WR_ACK,
  output logic [BEAT_W-1:0] WR_BEAT,
  output logic              WR_BEAT_VALID,
  output logic              WR_DONE,
  input  logic              RD_REQ,
  input  logic [BEAT_W-1:0] RD_BEAT,
  input  logic              RD_BEAT_VALID,
`ifdef DDR3_DP_PARITY_EN
  input  logic              RD_BEAT_PAR,
  output logic              RD_PAR_ERR,
`endif
  output logic [WORD_W-1:0] RD_WORD,
  output logic              RD_WORD_VALID,
  output logic              RD_ERR,
  output logic              BUSY
);

  localparam int IW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [IW-1:0] LAST = IW'(BL - 1);

  dp_state_t                 state;
  logic [BL-1:0][BEAT_W-1:0] wr_sh;
  logic [IW-1:0]             wr_idx, wr_nxt;
  logic                      rd_start, rd_active, rd_fin, rd_abort;

  assign wr_nxt    = wr_idx + IW'(1);
  assign rd_start  = (state == IDLE) && RD_REQ;
  assign rd_active = (state == RD_BURST);
  assign BUSY      = (state != IDLE);

  // Read has priority; a losing or busy-time write request is simply dropped.
  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      state         <= IDLE;
      wr_sh         <= '0;
      wr_idx        <= '0;
      WR_ACK        <= 1'b0;
      WR_BEAT       <= '0;
      WR_BEAT_VALID <= 1'b0;
      WR_DONE       <= 1'b0;
    end else begin
      WR_ACK <= 1'b0;
      unique case (state)
        IDLE: begin
          if (RD_REQ) begin
            state <= RD_BURST;
          end else if (WR_REQ) begin
            state         <= WR_BURST;
            wr_sh         <= {{BEAT_W{1'b0}}, WR_WORD[WORD_W-1:BEAT_W]};
            wr_idx        <= '0;
            WR_ACK        <= 1'b1;
            WR_BEAT       <= WR_WORD[BEAT_W-1:0];
            WR_BEAT_VALID <= 1'b1;
            WR_DONE       <= 1'b0;
          end
        end
        WR_BURST: begin
          if (wr_idx == LAST) begin
            state         <= IDLE;
            WR_BEAT       <= '0;
            WR_BEAT_VALID <= 1'b0;
            WR_DONE       <= 1'b0;
          end else begin
            wr_idx  <= wr_nxt;
            WR_BEAT <= wr_sh[0];
            wr_sh   <= {{BEAT_W{1'b0}}, wr_sh[BL-1:1]};
            WR_DONE <= (wr_nxt == LAST);
          end
        end
        RD_BURST: begin
          if (rd_fin || rd_abort) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ddr3_rd_assembler #(
    .BL         (BL),
    .BEAT_W     (BEAT_W),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd (
    .clk        (CPU_CLK),
    .rst        (RESET),
    .start      (rd_start),
    .active     (rd_active),
    .beat       (RD_BEAT),
    .beat_valid (RD_BEAT_VALID),
`ifdef DDR3_DP_PARITY_EN
    .beat_par   (RD_BEAT_PAR),
    .par_err    (RD_PAR_ERR),
`endif
    .fin        (rd_fin),
    .abort      (rd_abort),
    .word       (RD_WORD),
    .word_valid (RD_WORD_VALID),
    .err        (RD_ERR)
  );

endmodule

// File: tb/tb_ddr3_burst_datapath.sv
// Scenario bench for ddr3_burst_datapath with randomized words, beats and gaps.
module tb_ddr3_burst_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [63:0] wr_word;
  logic        wr_ack;
  logic [7:0]  wr_beat;
  logic        wr_beat_valid;
  logic        wr_done;
  logic        rd_req;
  logic [7:0]  rd_beat;
  logic        rd_beat_valid;
  logic [63:0] rd_word;
  logic        rd_word_valid;
  logic        rd_err;
  logic        busy;
`ifdef DDR3_DP_PARITY_EN
  logic        rd_beat_par;
  logic        rd_par_err;
`endif

  int          total = 0;
  int          bad = 0;
  logic [63:0] last_rd_word;

  always #5 clk = ~clk;

  ddr3_burst_datapath dut (
    .CPU_CLK       (clk),
    .RESET         (rst),
    .WR_REQ        (wr_req),
    .WR_WORD       (wr_word),
    .WR_ACK        (wr_ack),
    .WR_BEAT       (wr_beat),
    .WR_BEAT_VALID (wr_beat_valid),
    .WR_DONE       (wr_done),
    .RD_REQ        (rd_req),
    .RD_BEAT       (rd_beat),
    .RD_BEAT_VALID (rd_beat_valid),
`ifdef DDR3_DP_PARITY_EN
    .RD_BEAT_PAR   (rd_beat_par),
    .RD_PAR_ERR    (rd_par_err),
`endif
    .RD_WORD       (rd_word),
    .RD_WORD_VALID (rd_word_valid),
    .RD_ERR        (rd_err),
    .BUSY          (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    total++;
    if ({wr_ack, wr_beat_valid, wr_done, wr_beat} !== 11'd0) begin
      bad++;
      $display("FAIL reset_wr: got ack=%b v=%b done=%b beat=%h want 0", wr_ack, wr_beat_valid, wr_done, wr_beat);
    end
    total++;
    if ({rd_word_valid, rd_err, busy, rd_word} !== 67'd0) begin
      bad++;
      $display("FAIL reset_rd: got v=%b err=%b busy=%b word=%h want 0", rd_word_valid, rd_err, busy, rd_word);
    end
    rst = 1'b0;
    last_rd_word = '0;
  endtask

  // Write of w; with hold the request stays high and WR_WORD moves to wn during the burst.
  task automatic test_write(input logic [63:0] w, input bit hold, input logic [63:0] wn);
    logic [7:0] exp;
    wr_req  = 1'b1;
    wr_word = w;
    tick;
    if (hold) wr_word = wn;
    else wr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp = 8'(w >> (8 * i));
      total++;
      if (wr_beat_valid !== 1'b1 || wr_beat !== exp) begin
        bad++;
        $display("FAIL wr_beat[%0d]: got v=%b beat=%h want v=1 beat=%h", i, wr_beat_valid, wr_beat, exp);
      end
      total++;
      if (wr_ack !== (i == 0) || wr_done !== (i == 7) || busy !== 1'b1) begin
        bad++;
        $display("FAIL wr_flags[%0d]: got ack=%b done=%b busy=%b want ack=%b done=%b busy=1",
                 i, wr_ack, wr_done, busy, i == 0, i == 7);
      end
      if (i < 7) tick;
    end
    tick;
    total++;
    if ({busy, wr_beat_valid, wr_ack, wr_done, wr_beat} !== 12'd0) begin
      bad++;
      $display("FAIL wr_idle: got busy=%b v=%b ack=%b done=%b beat=%h want 0",
               busy, wr_beat_valid, wr_ack, wr_done, wr_beat);
    end
  endtask

  // Read of word w; gap before beat gpos is glen cycles, other gaps random when rnd.
  task automatic test_read(input logic [63:0] w, input bit rnd, input int gpos, input int glen, input int bad_beat);
    int gap;
    int err_seen;
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    err_seen = 0;
    for (int i = 0; i < 8; i++) begin
      gap = (i == gpos) ? glen : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int g = 0; g < gap; g++) begin
        rd_beat       = 8'($urandom);
        rd_beat_valid = 1'b0;
        tick;
        if (rd_err !== 1'b0 || rd_word_valid !== 1'b0 || busy !== 1'b1) err_seen++;
      end
      rd_beat       = 8'(w >> (8 * i));
      rd_beat_valid = 1'b1;
`ifdef DDR3_DP_PARITY_EN
      rd_beat_par = (^rd_beat) ^ (i == bad_beat);
`endif
      tick;
      if (i < 7 && (rd_word_valid !== 1'b0 || rd_err !== 1'b0 || busy !== 1'b1)) err_seen++;
    end
    rd_beat_valid = 1'b0;
`ifdef DDR3_DP_PARITY_EN
    rd_beat_par = 1'b0;
`endif
    total++;
    if (err_seen != 0) begin
      bad++;
      $display("FAIL rd_midburst: got %0d bad cycles want 0", err_seen);
    end
    total++;
    if (rd_word_valid !== 1'b1 || rd_word !== w || rd_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_done: got v=%b word=%h err=%b busy=%b want v=1 word=%h err=0 busy=0",
               rd_word_valid, rd_word, rd_err, busy, w);
    end
`ifdef DDR3_DP_PARITY_EN
    total++;
    if (rd_par_err !== (bad_beat >= 0 && bad_beat < 8)) begin
      bad++;
      $display("FAIL rd_par_err: got %b want %b", rd_par_err, bad_beat >= 0 && bad_beat < 8);
    end
`endif
    last_rd_word = w;
    tick;
    total++;
    if (rd_word_valid !== 1'b0 || rd_word !== w) begin
      bad++;
      $display("FAIL rd_hold: got v=%b word=%h want v=0 word=%h", rd_word_valid, rd_word, w);
    end
  endtask

  task automatic test_timeout(input int nbeats);
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      rd_beat       = 8'($urandom);
      rd_beat_valid = 1'b1;
      tick;
    end
    rd_beat_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick;
      total++;
      if (rd_err !== (k == 16) || busy !== (k < 16) || rd_word_valid !== 1'b0) begin
        bad++;
        $display("FAIL timeout[%0d]: got err=%b busy=%b v=%b want err=%b busy=%b v=0",
                 k, rd_err, busy, rd_word_valid, k == 16, k < 16);
      end
    end
    total++;
    if (rd_word !== last_rd_word) begin
      bad++;
      $display("FAIL timeout_word: got %h want %h", rd_word, last_rd_word);
    end
    tick;
    total++;
    if (rd_err !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: got err=%b want 0", rd_err);
    end
  endtask

  task automatic test_collision;
    logic [63:0] wr_w;
    logic [63:0] rd_w;
    int          ack_seen;
    wr_w = rnd64();
    rd_w = rnd64();
    ack_seen = 0;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    wr_word = wr_w;
    tick;
    rd_req = 1'b0;
    total++;
    if (busy !== 1'b1 || wr_ack !== 1'b0 || wr_beat_valid !== 1'b0) begin
      bad++;
      $display("FAIL coll_start: got busy=%b ack=%b v=%b want 1 0 0", busy, wr_ack, wr_beat_valid);
    end
    for (int i = 0; i < 8; i++) begin
      rd_beat       = 8'(rd_w >> (8 * i));
      rd_beat_valid = 1'b1;
`ifdef DDR3_DP_PARITY_EN
      rd_beat_par = ^rd_beat;
`endif
      tick;
      if (wr_ack !== 1'b0) ack_seen++;
    end
    rd_beat_valid = 1'b0;
    total++;
    if (ack_seen != 0 || rd_word_valid !== 1'b1 || rd_word !== rd_w) begin
      bad++;
      $display("FAIL coll_read: got acks=%0d v=%b word=%h want acks=0 v=1 word=%h",
               ack_seen, rd_word_valid, rd_word, rd_w);
    end
    last_rd_word = rd_w;
    tick;
    wr_req = 1'b0;
    total++;
    if (wr_ack !== 1'b1 || wr_beat_valid !== 1'b1 || wr_beat !== 8'(wr_w)) begin
      bad++;
      $display("FAIL coll_write: got ack=%b v=%b beat=%h want ack=1 v=1 beat=%h",
               wr_ack, wr_beat_valid, wr_beat, 8'(wr_w));
    end
    for (int i = 1; i < 8; i++) tick;
    total++;
    if (wr_done !== 1'b1 || wr_beat !== 8'(wr_w >> 56)) begin
      bad++;
      $display("FAIL coll_wr_last: got done=%b beat=%h want done=1 beat=%h", wr_done, wr_beat, 8'(wr_w >> 56));
    end
    tick;
  endtask

  task automatic test_reset_mid_write;
    logic [63:0] w;
    w = rnd64();
    wr_req  = 1'b1;
    wr_word = w;
    tick;
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    total++;
    if (wr_beat !== 8'(w >> 32)) begin
      bad++;
      $display("FAIL rstw_beat4: got %h want %h", wr_beat, 8'(w >> 32));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({wr_beat_valid, wr_done, busy, wr_beat} !== 11'd0 || rd_word !== 64'd0) begin
      bad++;
      $display("FAIL rstw_abort: got v=%b done=%b busy=%b beat=%h word=%h want 0",
               wr_beat_valid, wr_done, busy, wr_beat, rd_word);
    end
    last_rd_word = '0;
    tick;
    total++;
    if (wr_done !== 1'b0 || wr_beat_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstw_quiet: got done=%b v=%b want 0", wr_done, wr_beat_valid);
    end
    test_write(rnd64(), 1'b0, '0);
  endtask

  task automatic test_reset_mid_read;
    int noise;
    noise = 0;
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_beat       = 8'($urandom);
      rd_beat_valid = 1'b1;
      tick;
    end
    rd_beat_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    last_rd_word = '0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || rd_err !== 1'b0 || rd_word_valid !== 1'b0) noise++;
      tick;
    end
    total++;
    if (noise != 0) begin
      bad++;
      $display("FAIL rstr_quiet: got %0d noisy cycles want 0", noise);
    end
    test_read(rnd64(), 1'b1, -1, 0, -1);
  endtask

  task automatic test_idle_beats;
    int noise;
    noise = 0;
    for (int i = 0; i < 5; i++) begin
      rd_beat       = 8'($urandom);
      rd_beat_valid = 1'b1;
      tick;
      if (busy !== 1'b0 || rd_word_valid !== 1'b0 || rd_err !== 1'b0) noise++;
    end
    rd_beat_valid = 1'b0;
    total++;
    if (noise != 0) begin
      bad++;
      $display("FAIL idle_beats: got %0d reactions want 0", noise);
    end
    test_read(rnd64(), 1'b0, -1, 0, -1);
  endtask

  task automatic test_back_to_back;
    logic [63:0] w1;
    logic [63:0] w2;
    w1 = rnd64();
    w2 = rnd64();
    test_write(w1, 1'b1, w2);
    test_write(w2, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    wr_req = 1'b0;
    wr_word = '0;
    rd_req = 1'b0;
    rd_beat = '0;
    rd_beat_valid = 1'b0;
`ifdef DDR3_DP_PARITY_EN
    rd_beat_par = 1'b0;
`endif
    last_rd_word = '0;

    test_reset;
    test_write(64'h0807060504030201, 1'b0, '0);
    test_read(64'hA7A6A5A4A3A2A1A0, 1'b0, 4, 3, -1);
    test_timeout(2);
    test_collision;
    test_reset_mid_write;
    test_back_to_back;
    for (int n = 0; n < 4; n++) test_write(rnd64(), 1'b0, '0);
    for (int n = 0; n < 4; n++) test_read(rnd64(), 1'b1, -1, 0, -1);
    test_read(rnd64(), 1'b1, int'($urandom_range(0, 7)), 15, -1);
    test_timeout(0);
    test_timeout(7);
    test_idle_beats;
    test_reset_mid_read;
`ifdef DDR3_DP_PARITY_EN
    test_read(rnd64(), 1'b1, -1, 0, 5);
    test_read(rnd64(), 1'b1, -1, 0, -1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
